// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler
// Walks an M_T x N_T x K_T tile grid (k innermost, then n, then m) and runs the
// systolic engine once per tile through a level start/done handshake. For each
// tile it presents the input/weight/output buffer bases and the accumulate and
// write-out flags. Bases are advanced with adders only and wrap modulo 2^AW.
module matmul_tile_scheduler #(
  parameter int AW           = 8,
  parameter int TW           = 4,
  parameter int I_TILE_WORDS = 4,
  parameter int W_TILE_WORDS = 4,
  parameter int O_TILE_WORDS = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [TW-1:0] cfg_m_tiles_i,
  input  logic [TW-1:0] cfg_n_tiles_i,
  input  logic [TW-1:0] cfg_k_tiles_i,
  input  logic [AW-1:0] cfg_ib_base_i,
  input  logic [AW-1:0] cfg_wb_base_i,
  input  logic [AW-1:0] cfg_ob_base_i,
  input  logic          abort_i,
  output logic          mm_start_o,
  input  logic          mm_done_i,
  output logic [AW-1:0] mm_ib_base_o,
  output logic [AW-1:0] mm_wb_base_o,
  output logic [AW-1:0] mm_ob_base_o,
  output logic          mm_accum_o,
  output logic          mm_last_k_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RELEASE = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LP_IW  = AW'(I_TILE_WORDS);
  localparam logic [AW-1:0] LP_WW  = AW'(W_TILE_WORDS);
  localparam logic [AW-1:0] LP_OW  = AW'(O_TILE_WORDS);
  localparam logic [TW-1:0] LP_ONE = TW'(1);

  state_t        r_state;
  logic [TW-1:0] r_m;
  logic [TW-1:0] r_n;
  logic [TW-1:0] r_k;
  logic [TW-1:0] r_mt;
  logic [TW-1:0] r_nt;
  logic [TW-1:0] r_kt;
  // Job weight base, start of current input row (m) and of current weight column (n)
  logic [AW-1:0] r_wb_base;
  logic [AW-1:0] r_ib_row;
  logic [AW-1:0] r_wb_col;
  // Weight-buffer step for one k increment: N_T * W_TILE_WORDS
  logic [AW-1:0] r_wb_kstride;
  logic          r_abort;

  logic [AW-1:0] w_stride_term [TW];
  logic [AW-1:0] w_wb_kstride;
  logic          w_k_last;
  logic          w_n_last;
  logic          w_m_last;
  logic          w_last_tile;
  logic          w_cfg_zero;
  logic [TW-1:0] w_k_next;

  // N_T * W_TILE_WORDS built from shifted copies of the tile size, one per count bit
  genvar gi;
  generate
    for (gi = 0; gi < TW; gi++) begin : g_stride
      assign w_stride_term[gi] = {AW{cfg_n_tiles_i[gi]}} & (LP_WW << gi);
    end
  endgenerate

  // Sum the shifted partial products into the k stride
  always_comb begin
    w_wb_kstride = '0;
    for (int i = 0; i < TW; i++) begin
      w_wb_kstride = w_wb_kstride + w_stride_term[i];
    end
  end

  assign w_k_last    = (r_k == r_kt - LP_ONE);
  assign w_n_last    = (r_n == r_nt - LP_ONE);
  assign w_m_last    = (r_m == r_mt - LP_ONE);
  assign w_last_tile = w_k_last && w_n_last && w_m_last;
  assign w_k_next    = r_k + LP_ONE;
  assign w_cfg_zero  = (cfg_m_tiles_i == '0) || (cfg_n_tiles_i == '0) || (cfg_k_tiles_i == '0);

  // Scheduler FSM with every output registered
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= S_IDLE;
      r_m          <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_mt         <= '0;
      r_nt         <= '0;
      r_kt         <= '0;
      r_wb_base    <= '0;
      r_ib_row     <= '0;
      r_wb_col     <= '0;
      r_wb_kstride <= '0;
      r_abort      <= 1'b0;
      cfg_ready_o  <= 1'b1;
      mm_start_o   <= 1'b0;
      mm_ib_base_o <= '0;
      mm_wb_base_o <= '0;
      mm_ob_base_o <= '0;
      mm_accum_o   <= 1'b0;
      mm_last_k_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      aborted_o <= 1'b0;
      // Abort is remembered until the job finishes; the running tile is never cut
      if (r_state != S_IDLE && abort_i) begin
        r_abort <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_valid_i && cfg_ready_o) begin
            r_mt         <= cfg_m_tiles_i;
            r_nt         <= cfg_n_tiles_i;
            r_kt         <= cfg_k_tiles_i;
            r_m          <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_wb_base    <= cfg_wb_base_i;
            r_ib_row     <= cfg_ib_base_i;
            r_wb_col     <= cfg_wb_base_i;
            r_wb_kstride <= w_wb_kstride;
            r_abort      <= 1'b0;
            mm_ib_base_o <= cfg_ib_base_i;
            mm_wb_base_o <= cfg_wb_base_i;
            mm_ob_base_o <= cfg_ob_base_i;
            mm_accum_o   <= 1'b0;
            mm_last_k_o  <= (cfg_k_tiles_i == LP_ONE);
            cfg_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            if (w_cfg_zero) begin
              r_state <= S_FINISH;
            end else begin
              r_state    <= S_LAUNCH;
              mm_start_o <= 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          if (mm_done_i) begin
            mm_start_o <= 1'b0;
            r_state    <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (!mm_done_i) begin
            if (r_abort || abort_i || w_last_tile) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_ADVANCE;
            end
          end
        end

        S_ADVANCE: begin
          r_state    <= S_LAUNCH;
          mm_start_o <= 1'b1;
          if (!w_k_last) begin
            r_k          <= w_k_next;
            mm_ib_base_o <= mm_ib_base_o + LP_IW;
            mm_wb_base_o <= mm_wb_base_o + r_wb_kstride;
            mm_accum_o   <= 1'b1;
            mm_last_k_o  <= (w_k_next == r_kt - LP_ONE);
          end else begin
            // Output tile index m*N_T+n is consecutive across both n and m steps
            r_k          <= '0;
            mm_accum_o   <= 1'b0;
            mm_last_k_o  <= (r_kt == LP_ONE);
            mm_ob_base_o <= mm_ob_base_o + LP_OW;
            if (!w_n_last) begin
              r_n          <= r_n + LP_ONE;
              mm_ib_base_o <= r_ib_row;
              mm_wb_base_o <= r_wb_col + LP_WW;
              r_wb_col     <= r_wb_col + LP_WW;
            end else begin
              // Last k of the last n ends one tile short of the next input row
              r_n          <= '0;
              r_m          <= r_m + LP_ONE;
              mm_ib_base_o <= mm_ib_base_o + LP_IW;
              r_ib_row     <= mm_ib_base_o + LP_IW;
              mm_wb_base_o <= r_wb_base;
              r_wb_col     <= r_wb_base;
            end
          end
        end

        S_FINISH: begin
          done_o      <= 1'b1;
          aborted_o   <= r_abort;
          r_abort     <= 1'b0;
          busy_o      <= 1'b0;
          cfg_ready_o <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          mm_start_o  <= 1'b0;
          busy_o      <= 1'b0;
          cfg_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: an engine responder with adjustable latency
// and done-hold, a per-cycle monitor against a queue of expected tiles built
// from the GEMM tile formulas, and a directed-plus-random job sequence.
module tb_matmul_tile_scheduler;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int IW = 4;
  localparam int WW = 4;
  localparam int OW = 4;

  typedef struct packed {
    logic [7:0] ib;
    logic [7:0] wb;
    logic [7:0] ob;
    logic       acc;
    logic       lk;
  } tile_t;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [TW-1:0] cfg_m_tiles_i;
  logic [TW-1:0] cfg_n_tiles_i;
  logic [TW-1:0] cfg_k_tiles_i;
  logic [AW-1:0] cfg_ib_base_i;
  logic [AW-1:0] cfg_wb_base_i;
  logic [AW-1:0] cfg_ob_base_i;
  logic          abort_i;
  logic          mm_start_o;
  logic          mm_done_i;
  logic [AW-1:0] mm_ib_base_o;
  logic [AW-1:0] mm_wb_base_o;
  logic [AW-1:0] mm_ob_base_o;
  logic          mm_accum_o;
  logic          mm_last_k_o;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;

  matmul_tile_scheduler #(
    .AW(AW), .TW(TW), .I_TILE_WORDS(IW), .W_TILE_WORDS(WW), .O_TILE_WORDS(OW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_m_tiles_i(cfg_m_tiles_i), .cfg_n_tiles_i(cfg_n_tiles_i), .cfg_k_tiles_i(cfg_k_tiles_i),
    .cfg_ib_base_i(cfg_ib_base_i), .cfg_wb_base_i(cfg_wb_base_i), .cfg_ob_base_i(cfg_ob_base_i),
    .abort_i(abort_i), .mm_start_o(mm_start_o), .mm_done_i(mm_done_i),
    .mm_ib_base_o(mm_ib_base_o), .mm_wb_base_o(mm_wb_base_o), .mm_ob_base_o(mm_ob_base_o),
    .mm_accum_o(mm_accum_o), .mm_last_k_o(mm_last_k_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Engine knobs: cycles from start to done, cycles done stays high after start falls
  int eng_lat  = 5;
  int eng_hold = 0;
  int e_st;
  int e_cnt;

  // Engine responder
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mm_done_i <= 1'b0;
      e_st      <= 0;
      e_cnt     <= 0;
    end else begin
      case (e_st)
        0: if (mm_start_o) begin e_st <= 1; e_cnt <= 1; end
        1: if (e_cnt >= eng_lat) begin mm_done_i <= 1'b1; e_st <= 2; end
           else e_cnt <= e_cnt + 1;
        2: if (!mm_start_o) begin
             if (eng_hold == 0) begin mm_done_i <= 1'b0; e_st <= 0; end
             else begin e_st <= 3; e_cnt <= 1; end
           end
        default: if (e_cnt >= eng_hold) begin mm_done_i <= 1'b0; e_st <= 0; end
                 else e_cnt <= e_cnt + 1;
      endcase
    end
  end

  tile_t exp_q[$];
  tile_t cur;
  bit    cur_valid;
  logic  prev_start;
  int    low_run;
  bit    seen_start;
  int    starts_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle and run the output monitor at the falling edge
  task automatic tick();
    tile_t obs;
    @(negedge clk_i);
    if (rstn_i) begin
      obs = '{ib: mm_ib_base_o, wb: mm_wb_base_o, ob: mm_ob_base_o, acc: mm_accum_o, lk: mm_last_k_o};
      if (mm_start_o && !prev_start) begin
        if (seen_start) chk("start_gap_ge2", 32'(low_run >= 2), 1);
        chk("start_while_done", mm_done_i, 0);
        if (exp_q.size() == 0) begin
          chk("extra_start", 1, 0);
          cur_valid = 0;
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1;
          chk("tile_ib", obs.ib, cur.ib);
          chk("tile_wb", obs.wb, cur.wb);
          chk("tile_ob", obs.ob, cur.ob);
          chk("tile_accum", obs.acc, cur.acc);
          chk("tile_last_k", obs.lk, cur.lk);
        end
        starts_total++;
        seen_start = 1;
      end else if (mm_start_o && cur_valid) begin
        chk("tile_stable", 32'(obs), 32'(cur));
      end
      if (e_st == 3) chk("no_start_in_hold", mm_start_o, 0);
      low_run    = mm_start_o ? 0 : low_run + 1;
      prev_start = mm_start_o;
    end
  endtask

  task automatic run_job(input int mt, input int nt, input int kt,
                         input logic [7:0] ib, input logic [7:0] wb, input logic [7:0] ob,
                         input int abort_at);
    int s0, want, cyc;
    bit got, sent;
    exp_q.delete();
    for (int m = 0; m < mt; m++)
      for (int n = 0; n < nt; n++)
        for (int k = 0; k < kt; k++)
          exp_q.push_back('{ib: 8'(int'(ib) + (m * kt + k) * IW),
                            wb: 8'(int'(wb) + (k * nt + n) * WW),
                            ob: 8'(int'(ob) + (m * nt + n) * OW),
                            acc: (k != 0), lk: (k == kt - 1)});
    want = (abort_at >= 0) ? abort_at + 1 : mt * nt * kt;
    tick();
    chk("ready_idle", cfg_ready_o, 1);
    s0 = starts_total;
    cfg_valid_i   = 1'b1;
    cfg_m_tiles_i = TW'(mt);
    cfg_n_tiles_i = TW'(nt);
    cfg_k_tiles_i = TW'(kt);
    cfg_ib_base_i = ib;
    cfg_wb_base_i = wb;
    cfg_ob_base_i = ob;
    tick();
    cfg_valid_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
    chk("first_start_next_cycle", mm_start_o, 1);
    got = 0; sent = 0; cyc = 0;
    while (!got && cyc < 3000) begin
      if (abort_at >= 0 && !sent && starts_total - s0 == abort_at + 1) begin
        abort_i = 1'b1;
        sent = 1;
      end
      tick();
      abort_i = 1'b0;
      cyc++;
      if (done_o) got = 1;
    end
    chk("job_done_seen", 32'(got), 1);
    if (got) begin
      chk("aborted_flag", aborted_o, 32'(abort_at >= 0));
      chk("start_count", 32'(starts_total - s0), 32'(want));
      chk("ready_with_done", cfg_ready_o, 1);
      chk("idle_with_done", busy_o, 0);
      tick();
      chk("done_one_cycle", done_o, 0);
    end
  endtask

  initial begin
    int mt, nt, kt, s0;
    rstn_i = 1'b0; cfg_valid_i = 1'b0; abort_i = 1'b0;
    cfg_m_tiles_i = '0; cfg_n_tiles_i = '0; cfg_k_tiles_i = '0;
    cfg_ib_base_i = '0; cfg_wb_base_i = '0; cfg_ob_base_i = '0;
    prev_start = 1'b0; low_run = 0; seen_start = 0; cur_valid = 0; cur = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_start", mm_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_aborted", aborted_o, 0);
    chk("rst_ib", mm_ib_base_o, 0);
    chk("rst_wb", mm_wb_base_o, 0);
    chk("rst_ob", mm_ob_base_o, 0);
    chk("rst_accum", mm_accum_o, 0);
    chk("rst_last_k", mm_last_k_o, 0);
    rstn_i = 1'b1;

    // Single tile
    eng_lat = 5; eng_hold = 0;
    run_job(1, 1, 1, 8'h10, 8'h20, 8'h30, -1);
    // 2x2x2 grid
    eng_lat = 2; eng_hold = 0;
    run_job(2, 2, 2, 8'h00, 8'h00, 8'h00, -1);
    // Engine keeps done high after start falls
    eng_lat = 3; eng_hold = 3;
    run_job(1, 2, 2, 8'h40, 8'h80, 8'hC0, -1);
    // Abort during the third tile, then a normal job
    eng_lat = 4; eng_hold = 1;
    run_job(3, 2, 2, 8'h00, 8'h00, 8'h00, 2);
    run_job(2, 1, 2, 8'h05, 8'h06, 8'h07, -1);

    // Zero k count: no start, done two cycles after acceptance, valid ignored while busy
    tick();
    s0 = starts_total;
    cfg_valid_i = 1'b1;
    cfg_m_tiles_i = 4'd1; cfg_n_tiles_i = 4'd1; cfg_k_tiles_i = 4'd0;
    tick();
    cfg_m_tiles_i = 4'd2; cfg_n_tiles_i = 4'd2; cfg_k_tiles_i = 4'd2;
    chk("k0_busy", busy_o, 1);
    chk("k0_not_ready", cfg_ready_o, 0);
    chk("k0_no_done_yet", done_o, 0);
    tick();
    cfg_valid_i = 1'b0;
    chk("k0_done", done_o, 1);
    chk("k0_not_aborted", aborted_o, 0);
    tick();
    chk("k0_done_cleared", done_o, 0);
    chk("k0_valid_ignored", busy_o, 0);
    repeat (3) tick();
    chk("k0_no_start", 32'(starts_total - s0), 0);

    // Output base wraps modulo 2^AW
    eng_lat = 2; eng_hold = 0;
    run_job(1, 2, 1, 8'hF0, 8'hF8, 8'hFC, -1);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      mt = int'($urandom_range(1, 3));
      nt = int'($urandom_range(1, 3));
      kt = int'($urandom_range(1, 3));
      eng_lat  = int'($urandom_range(1, 6));
      eng_hold = int'($urandom_range(0, 3));
      run_job(mt, nt, kt, 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, mt * nt * kt - 1)) : -1);
    end

    // Reset asserted while a tile is launched
    eng_lat = 20; eng_hold = 0;
    exp_q.delete();
    exp_q.push_back('{ib: 8'h00, wb: 8'h00, ob: 8'hFC, acc: 1'b0, lk: 1'b1});
    tick();
    cfg_valid_i = 1'b1;
    cfg_m_tiles_i = 4'd1; cfg_n_tiles_i = 4'd2; cfg_k_tiles_i = 4'd1;
    cfg_ib_base_i = 8'h00; cfg_wb_base_i = 8'h00; cfg_ob_base_i = 8'hFC;
    tick();
    cfg_valid_i = 1'b0;
    repeat (2) tick();
    chk("pre_rst_start", mm_start_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("midrst_start", mm_start_o, 0);
    chk("midrst_ready", cfg_ready_o, 1);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ob", mm_ob_base_o, 0);
    chk("midrst_last_k", mm_last_k_o, 0);
    chk("midrst_done", done_o, 0);
    prev_start = 1'b0; seen_start = 0; cur_valid = 0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    eng_lat = 2;
    run_job(1, 1, 2, 8'h11, 8'h22, 8'h33, -1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
- Sequences repeated runs of the systolic matrix-multiply engine to compute a large GEMM as an M_T x N_T x K_T grid of ROWxCOL tiles.
- Per tile: drives the engine start, the buffer base addresses and the accumulate/write-out flags.
- Handles the engine's start/done handshake, including the required start return-to-0 between runs.
- Sits between the host config interface and the engine's start/config/done ports.

Parameters:
AW, 8, buffer address width (matches $clog2 of W_SIZE/I_SIZE/O_SIZE).
TW, 4, width of each tile-count field.
I_TILE_WORDS, 4, input-buffer words per tile (ROW).
W_TILE_WORDS, 4, weight-buffer words per tile.
O_TILE_WORDS, 4, output-buffer words per tile.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_valid_i  in  1  job request
cfg_ready_o  out  1  high only in IDLE; job accepted when valid&&ready
cfg_m_tiles_i  in  TW  row-tile count
cfg_n_tiles_i  in  TW  column-tile count
cfg_k_tiles_i  in  TW  reduction-tile count
cfg_ib_base_i  in  AW  input buffer base
cfg_wb_base_i  in  AW  weight buffer base
cfg_ob_base_i  in  AW  output buffer base
abort_i  in  1  stop job after the current tile
mm_start_o  out  1  engine start (level)
mm_done_i  in  1  engine done (level; engine clears it after start falls)
mm_ib_base_o  out  AW  tile input base
mm_wb_base_o  out  AW  tile weight base
mm_ob_base_o  out  AW  tile output base
mm_accum_o  out  1  1 = add partial-sum buffer (k>0)
mm_last_k_o  out  1  1 = write result to output buffer (k==K_T-1)
busy_o  out  1  job in progress
done_o  out  1  one-cycle job-complete pulse
aborted_o  out  1  valid with done_o; job ended by abort

Behaviour:
- Every output is a register. Reset values: all 0, except cfg_ready_o=1.
- Async reset mid-job returns to IDLE immediately.
- States: IDLE, LAUNCH, RELEASE, ADVANCE, FINISH.
- IDLE:
  - On valid&&ready, latch the cfg fields and clear m,n,k.
  - Any count==0: go to FINISH; no start is issued.
  - Otherwise: go to LAUNCH.
  - cfg_valid_i is ignored in every other state.
- LAUNCH: mm_start_o=1, with the tile outputs stable.
  - First start is asserted the cycle after acceptance.
  - Stays in LAUNCH until mm_done_i is sampled 1, then goes to RELEASE.
- RELEASE: mm_start_o=0. Waits for mm_done_i==0; holds any number of cycles.
  - Then: abort pending or last tile → FINISH; else → ADVANCE.
- ADVANCE: one cycle; increments indices, then → LAUNCH.
  - Loop order: k innermost, then n, then m outermost.
  - Guarantees at least 2 cycles of start low between tiles.
- FINISH: done_o=1 for one cycle; aborted_o=abort latch. Then → IDLE; cfg_ready_o=1 the following cycle.
- Tile outputs:
  - mm_ib_base_o = ib_base + (m*K_T+k)*I_TILE_WORDS
  - mm_wb_base_o = wb_base + (k*N_T+n)*W_TILE_WORDS
  - mm_ob_base_o = ob_base + (m*N_T+n)*O_TILE_WORDS
  - mm_accum_o = (k!=0); mm_last_k_o = (k==K_T-1).
  - Bases are computed incrementally with adders (no multipliers) and truncated modulo 2^AW (wrap, no error).
- abort_i: a pulse in any non-IDLE state sets a sticky latch; the latch clears at FINISH.
  - The in-flight engine run is never cut: start stays high until done.
  - Abort during ADVANCE still takes effect after the next tile.
- busy_o = state != IDLE.
- mm_done_i high while in IDLE or ADVANCE is ignored.

Test Plan:
- M=N=K=1, bases 0x10/0x20/0x30; engine done 5 cycles after start → one start, bases 0x10/0x20/0x30, accum=0, last_k=1, done_o pulse, aborted_o=0.
- M=N=K=2, bases 0, tile words 4 → 8 tiles in order (m,n,k)=000,001,010,011,100,...
  - ib bases 0,4,0,4,8,12,8,12; wb bases 0,8,4,12,0,8,4,12; ob bases 0,0,4,4,8,8,12,12.
  - accum alternates 0/1; start low ≥2 cycles between tiles.
- Engine holds done high 3 cycles after start falls → scheduler stays in RELEASE until done=0; no new start meanwhile.
- M=3, N=K=2, abort_i pulsed during tile 2's LAUNCH → tile 2 completes, no further start, done_o=1 with aborted_o=1; next job runs normally with aborted_o=0.
- cfg_k_tiles_i=0 → no mm_start_o; done_o pulses 2 cycles after acceptance; cfg_valid_i held high while busy is not accepted.
- ob_base=0xFC, M=1, N=2, K=1, AW=8 → ob bases 0xFC then 0x00 (wrap); rstn_i asserted mid-LAUNCH → all outputs reset, cfg_ready_o=1.
